// File: rtl/ota_reboot_req.sv
// rtl/ota_reboot_req.sv - framed reboot-address command parser with hold-off and one-shot trigger
// Accepts A5 5A A3 A2 A1 A0 CS, validates it, then fires a single reboot pulse per reset.
module ota_reboot_req #(
  parameter int unsigned BYTE_TIMEOUT   = 1_000_000,
  parameter int unsigned HOLDOFF_CYCLES = 1024,
  parameter logic [31:0] ADDR_MIN       = 32'h0010_0000,
  parameter logic [31:0] ADDR_MAX       = 32'h00FF_0000,
  parameter int unsigned ALIGN_BITS     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        trigger,
  output logic [31:0] address,
  output logic        busy,
  output logic        err_csum,
  output logic        err_addr,
  output logic        err_timeout
);

  localparam int TW = $clog2(BYTE_TIMEOUT) + 1;
  localparam int HW = $clog2(HOLDOFF_CYCLES) + 1;
  localparam logic [TW-1:0] TO_LAST    = TW'(BYTE_TIMEOUT - 1);
  localparam logic [HW-1:0] HO_LAST    = HW'(HOLDOFF_CYCLES - 1);
  localparam logic [31:0]   ALIGN_MASK = 32'((64'd1 << ALIGN_BITS) - 64'd1);

  typedef enum logic [2:0] {
    S_IDLE, S_MAGIC2, S_ADDR, S_CSUM, S_CHECK, S_HOLDOFF, S_FIRE, S_DONE
  } state_e;

  // Reset asserts asynchronously but releases two clocks later, in step with clk.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_int_n;

  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= rst_sync_d;
  end

  assign rst_int_n = rst_sync_q[1];

  state_e          state_q, state_d;
  logic [31:0]     addr_shift_q, addr_shift_d;
  logic [1:0]      idx_q, idx_d;
  logic [7:0]      cs_q, cs_d;
  logic [31:0]     address_q, address_d;
  logic            busy_q, busy_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;

  logic            ready_state;
  logic            rx_fire;
  logic [7:0]      exp_cs;
  logic            csum_bad;
  logic            addr_bad;
  logic            timed_state;
  logic            timeout_hit;

  always_comb begin
    ready_state = (state_q == S_IDLE) || (state_q == S_MAGIC2) ||
                  (state_q == S_ADDR) || (state_q == S_CSUM);
    rx_ready    = ready_state && rst_int_n;
    rx_fire     = rx_valid && rx_ready;
    exp_cs      = addr_shift_q[31:24] ^ addr_shift_q[23:16] ^
                  addr_shift_q[15:8]  ^ addr_shift_q[7:0] ^ 8'hFF;
    csum_bad    = (cs_q != exp_cs);
    addr_bad    = (addr_shift_q < ADDR_MIN) || (addr_shift_q > ADDR_MAX) ||
                  ((addr_shift_q & ALIGN_MASK) != 32'h0);
    timed_state = (state_q == S_MAGIC2) || (state_q == S_ADDR) || (state_q == S_CSUM);
    // An arriving byte always beats an expiring timeout.
    timeout_hit = timed_state && (to_cnt_q == TO_LAST) && !rx_fire;
  end

  always_comb begin
    state_d      = state_q;
    addr_shift_d = addr_shift_q;
    idx_d        = idx_q;
    cs_d         = cs_q;
    address_d    = address_q;
    busy_d       = busy_q;
    to_cnt_d     = '0;
    hold_cnt_d   = hold_cnt_q;
    trigger      = 1'b0;
    err_csum     = 1'b0;
    err_addr     = 1'b0;
    err_timeout  = 1'b0;

    if (timed_state) begin
      to_cnt_d = rx_fire ? '0 : to_cnt_q + 1'b1;
    end

    if (timeout_hit) begin
      err_timeout = 1'b1;
      state_d     = S_IDLE;
      to_cnt_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rx_fire && rx_data == 8'hA5) state_d = S_MAGIC2;
        end
        S_MAGIC2: begin
          if (rx_fire) begin
            if (rx_data == 8'h5A) begin
              state_d = S_ADDR;
              idx_d   = 2'd0;
            end else if (rx_data != 8'hA5) begin
              state_d = S_IDLE;
            end
          end
        end
        S_ADDR: begin
          if (rx_fire) begin
            addr_shift_d = {addr_shift_q[23:0], rx_data};
            idx_d        = idx_q + 2'd1;
            if (idx_q == 2'd3) state_d = S_CSUM;
          end
        end
        S_CSUM: begin
          if (rx_fire) begin
            cs_d    = rx_data;
            state_d = S_CHECK;
          end
        end
        S_CHECK: begin
          if (csum_bad) begin
            err_csum = 1'b1;
            state_d  = S_IDLE;
          end else if (addr_bad) begin
            err_addr = 1'b1;
            state_d  = S_IDLE;
          end else begin
            address_d  = addr_shift_q;
            busy_d     = 1'b1;
            hold_cnt_d = '0;
            state_d    = S_HOLDOFF;
          end
        end
        S_HOLDOFF: begin
          if (hold_cnt_q == HO_LAST) state_d = S_FIRE;
          else                       hold_cnt_d = hold_cnt_q + 1'b1;
        end
        S_FIRE: begin
          trigger = 1'b1;
          state_d = S_DONE;
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q      <= S_IDLE;
      addr_shift_q <= 32'h0;
      idx_q        <= 2'd0;
      cs_q         <= 8'h0;
      address_q    <= 32'h0;
      busy_q       <= 1'b0;
      to_cnt_q     <= '0;
      hold_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      addr_shift_q <= addr_shift_d;
      idx_q        <= idx_d;
      cs_q         <= cs_d;
      address_q    <= address_d;
      busy_q       <= busy_d;
      to_cnt_q     <= to_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  assign address = address_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_ota_reboot_req.sv
// tb/tb_ota_reboot_req.sv - directed bench for ota_reboot_req
module tb_ota_reboot_req;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready, trigger, busy, err_csum, err_addr, err_timeout;
  logic [31:0] address;

  int n_checks = 0;
  int n_pass   = 0;

  int trig_cnt, trig_at, csum_cnt, csum_at, addr_cnt, addr_at, to_cnt, to_at, busy_at;

  ota_reboot_req #(
    .BYTE_TIMEOUT(16), .HOLDOFF_CYCLES(8),
    .ADDR_MIN(32'h0010_0000), .ADDR_MAX(32'h00FF_0000), .ALIGN_BITS(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .trigger(trigger), .address(address), .busy(busy),
    .err_csum(err_csum), .err_addr(err_addr), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] a, input logic [7:0] cs);
    send(8'hA5); send(8'h5A);
    send(a[31:24]); send(a[23:16]); send(a[15:8]); send(a[7:0]);
    send(cs);
  endtask

  // Samples n consecutive cycles; cycle 1 is the one right after the last accepted byte.
  task automatic observe(input int n);
    trig_cnt = 0; trig_at = 0; csum_cnt = 0; csum_at = 0;
    addr_cnt = 0; addr_at = 0; to_cnt = 0; to_at = 0; busy_at = 0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (trigger)     begin trig_cnt++; if (trig_at == 0) trig_at = k; end
      if (err_csum)    begin csum_cnt++; if (csum_at == 0) csum_at = k; end
      if (err_addr)    begin addr_cnt++; if (addr_at == 0) addr_at = k; end
      if (err_timeout) begin to_cnt++;   if (to_at == 0)   to_at = k;   end
      if (busy && busy_at == 0) busy_at = k;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  logic [31:0] bad_addr [3];
  logic [7:0]  bad_cs   [3];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bad_addr[0] = 32'h0008_0000; bad_cs[0] = 8'hF7;
    bad_addr[1] = 32'h0020_1000; bad_cs[1] = 8'hCF;
    bad_addr[2] = 32'h0100_0000; bad_cs[2] = 8'hFE;

    repeat (2) @(negedge clk);
    check("rst_trigger", {31'h0, trigger}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_address", address, 32'h0);
    check("rst_errs", {29'h0, err_csum, err_addr, err_timeout}, 32'h0);
    check("rst_rx_ready", {31'h0, rx_ready}, 32'h0);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("idle_rx_ready", {31'h0, rx_ready}, 32'h1);

    send_frame(32'h0020_0000, 8'hDE);
    observe(12);
    check("csum_cnt", csum_cnt, 1);
    check("csum_at", csum_at, 1);
    check("csum_no_addr_err", addr_cnt, 0);
    check("csum_no_trig", trig_cnt, 0);
    check("csum_busy", {31'h0, busy}, 32'h0);
    check("csum_address", address, 32'h0);

    for (int i = 0; i < 3; i++) begin
      send_frame(bad_addr[i], bad_cs[i]);
      observe(12);
      check($sformatf("addr_err_cnt%0d", i), addr_cnt, 1);
      check($sformatf("addr_err_at%0d", i), addr_at, 1);
      check($sformatf("addr_no_csum%0d", i), csum_cnt, 0);
      check($sformatf("addr_no_trig%0d", i), trig_cnt, 0);
    end
    check("addr_address", address, 32'h0);

    send(8'hA5); send(8'h5A); send(8'h00);
    observe(20);
    check("to_cnt", to_cnt, 1);
    check("to_at", to_at, 16);
    check("to_idle_ready", {31'h0, rx_ready}, 32'h1);

    send(8'hA5); send(8'h5A); send(8'h00);
    observe(15);
    check("late_no_to_idle", to_cnt, 0);
    @(posedge clk); #1;
    send(8'h20); send(8'h00); send(8'h00); send(8'hDE);
    observe(3);
    check("late_byte_wins_to", to_cnt, 0);
    check("late_byte_csum", csum_cnt, 1);

    send_frame(32'h0020_0000, 8'hDF);
    observe(14);
    check("good_busy_at", busy_at, 2);
    check("good_trig_cnt", trig_cnt, 1);
    check("good_trig_at", trig_at, 10);
    check("good_no_errs", csum_cnt + addr_cnt + to_cnt, 0);
    check("good_address", address, 32'h0020_0000);

    check("done_rx_ready", {31'h0, rx_ready}, 32'h0);
    send_frame(32'h0030_0000, 8'hCF);
    observe(14);
    check("done_no_trig", trig_cnt, 0);
    check("done_address", address, 32'h0020_0000);
    check("done_busy", {31'h0, busy}, 32'h1);

    do_reset();
    check("reset2_address", address, 32'h0);
    send(8'h11); send(8'hA5);
    send_frame(32'h0030_0000, 8'hCF);
    observe(14);
    check("noise_trig_cnt", trig_cnt, 1);
    check("noise_trig_at", trig_at, 10);
    check("noise_address", address, 32'h0030_0000);

    do_reset();
    send_frame(32'h0020_0000, 8'hDF);
    observe(5);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check("midrst_address", address, 32'h0);
    check("midrst_outs", {27'h0, trigger, err_csum, err_addr, err_timeout, rx_ready}, 32'h0);
    observe(15);
    check("midrst_no_trig", trig_cnt, 0);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    send_frame(32'h0020_0000, 8'hDF);
    observe(14);
    check("after_rst_trig_cnt", trig_cnt, 1);
    check("after_rst_trig_at", trig_at, 10);
    check("after_rst_address", address, 32'h0020_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ota_reboot_req.md
Name: ota_reboot_req

Overview:
- Upstream command stage for the ECP5 reboot driver. It receives a framed "reboot to address" request as a byte stream from the RP2040 link receiver (UART/SPI slave byte output).
- It checks the frame's magic, checksum and address range.
- After a fixed hold-off, it presents a stable 32-bit boot address and a single-cycle trigger pulse to the reboot driver.
- It locks after firing, so exactly one reboot request can be issued per reset.

Parameters:
- BYTE_TIMEOUT, 1_000_000: maximum idle cycles between bytes inside a frame before the frame is aborted.
- HOLDOFF_CYCLES, 1024: cycles between frame acceptance and trigger assertion; lets the link flush its ack. Must be ≥1.
- ADDR_MIN, 32'h0010_0000: lowest legal boot address.
- ADDR_MAX, 32'h00FF_0000: highest legal boot address.
- ALIGN_BITS, 16: address low ALIGN_BITS must be zero (64 KiB sector alignment).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  byte accepted when rx_valid && rx_ready
- trigger  out  1  one-cycle reboot pulse to the reboot driver
- address  out  32  boot address to the reboot driver
- busy  out  1  high from frame acceptance until reset
- err_csum  out  1  one-cycle pulse: checksum mismatch
- err_addr  out  1  one-cycle pulse: address out of range or misaligned
- err_timeout  out  1  one-cycle pulse: inter-byte timeout

Behaviour:
- Reset (async assert, sync deassert inside block): all outputs 0, address = 0, state IDLE, counters 0.
- Frame format: A5, 5A, A3, A2, A1, A0 (address big-endian), CS, where CS = A3^A2^A1^A0^8'hFF.
- rx_ready = 1 in states IDLE, MAGIC2, ADDR, CSUM; 0 otherwise. Byte consumption happens only on the handshake.
- States:
  - IDLE: a byte of A5 goes to MAGIC2; any other byte is discarded silently.
  - MAGIC2: 5A goes to ADDR with byte index 0. A5 stays in MAGIC2. Any other byte goes to IDLE with no error.
  - ADDR: shift the byte into addr_shift = {addr_shift[23:0], byte}. After the 4th byte, go to CSUM.
  - CSUM: latch the received CS and go to CHECK.
  - CHECK (1 cycle, no input):
    - CS mismatch: err_csum pulse, go to IDLE.
    - Otherwise, addr < ADDR_MIN, addr > ADDR_MAX, or low bits nonzero: err_addr pulse, go to IDLE.
    - Otherwise: address <= addr_shift, busy <= 1, go to HOLDOFF.
    - Checksum is tested before address; only one error pulse fires per frame.
  - HOLDOFF: counts HOLDOFF_CYCLES cycles, then goes to FIRE.
  - FIRE: trigger = 1 for exactly this cycle, then go to DONE.
  - DONE: terminal state. trigger = 0, busy = 1, rx_ready = 0, address held. Only reset exits.
- Latency: if the CS byte is accepted at cycle N, CHECK occurs at N+1, HOLDOFF spans N+2 … N+1+HOLDOFF_CYCLES, and trigger is high at cycle N+2+HOLDOFF_CYCLES.
- Timeout:
  - A counter runs in MAGIC2, ADDR and CSUM. It clears on each accepted byte and on entry from IDLE.
  - When it reaches BYTE_TIMEOUT-1 without a byte: err_timeout pulse, go to IDLE, discard the partial frame.
  - The counter does not run in IDLE, CHECK, HOLDOFF, FIRE or DONE.
- Simultaneous events: if a byte is accepted in the same cycle the timeout would expire, the byte wins and there is no timeout.
- address changes only on a passing CHECK; failed frames never disturb it. Before the first good frame it reads 0.
- rx_valid while rx_ready = 0 is ignored. Bytes are left unconsumed; upstream must drop them.
- Reset mid-HOLDOFF aborts the reboot: trigger never pulses, and all state clears immediately.
- Error pulses are one cycle, mutually exclusive, and never coincide with trigger.

Test Plan:
- Good frame A5 5A 00 20 00 00 DF, HOLDOFF_CYCLES=8, one byte per cycle → address = 32'h0020_0000 and busy = 1 at N+2; a single trigger pulse at N+10; nothing else fires.
- Same frame with CS = DE → err_csum pulse at N+1; address stays 0; busy = 0; next good frame is accepted normally.
- Frames with address 0x0008_0000 (below min), 0x0020_1000 (misaligned) and 0x0100_0000 (above max), each with correct CS → err_addr pulse for each; no trigger.
- Send A5 5A 00, then stall BYTE_TIMEOUT=16 cycles → err_timeout exactly 16 cycles after the last byte; state IDLE; subsequent good frame fires.
- Leading noise 11 A5 A5 5A 00 30 00 00 CF → resynchronises and fires with address 32'h0030_0000. A second good frame after DONE sees rx_ready = 0 and produces no second trigger.
- Assert rst_n = 0 midway through HOLDOFF → trigger never asserts; all outputs 0; after release, a good frame works.
